// File: rtl/mor1kx_wb_stage_cappuccino.sv
// Writeback stage: registers ALU results or aligned load data toward the GPR file.
// Ports: ctrl_* from control stage, lsu_* load return, wb_* / result_o to RF and bypass.
module mor1kx_wb_stage_cappuccino #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            padv_wb_i,
  input  logic                            pipeline_flush_i,
  input  logic                            ctrl_rf_wb_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] ctrl_rfd_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_alu_result_i,
  input  logic                            ctrl_op_lsu_load_i,
  input  logic [1:0]                      ctrl_lsu_length_i,
  input  logic                            ctrl_lsu_zext_i,
  input  logic [1:0]                      ctrl_lsu_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] lsu_dat_i,
  input  logic                            lsu_valid_i,
  output logic                            wb_rf_wb_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] result_o,
  output logic                            wb_stall_o
);

  localparam int W = OPTION_OPERAND_WIDTH;
  localparam int A = OPTION_RF_ADDR_WIDTH;

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  state_t         state_q, state_d;
  logic           rf_wb_q, rf_wb_d;
  logic [A-1:0]   rfd_q, rfd_d;
  logic [W-1:0]   result_q, result_d;
  logic           ld_rf_wb_q, ld_rf_wb_d;
  logic [A-1:0]   ld_rfd_q, ld_rfd_d;
  logic [1:0]     ld_len_q, ld_len_d;
  logic           ld_zext_q, ld_zext_d;
  logic [1:0]     ld_adr_q, ld_adr_d;

  // Big-endian lane select then zero/sign extension.
  function automatic logic [W-1:0] align(
    input logic [W-1:0] dat,
    input logic [1:0]   len,
    input logic         zext,
    input logic [1:0]   adr
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [W-1:0] r;
    case (adr)
      2'd0:    b = dat[31:24];
      2'd1:    b = dat[23:16];
      2'd2:    b = dat[15:8];
      default: b = dat[7:0];
    endcase
    h = adr[1] ? dat[15:0] : dat[31:16];
    case (len)
      2'b00:   r = zext ? {{(W-8){1'b0}}, b} : {{(W-8){b[7]}}, b};
      2'b01:   r = zext ? {{(W-16){1'b0}}, h} : {{(W-16){h[15]}}, h};
      default: r = dat;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    rf_wb_d    = 1'b0;
    rfd_d      = rfd_q;
    result_d   = result_q;
    ld_rf_wb_d = ld_rf_wb_q;
    ld_rfd_d   = ld_rfd_q;
    ld_len_d   = ld_len_q;
    ld_zext_d  = ld_zext_q;
    ld_adr_d   = ld_adr_q;
    if (pipeline_flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (padv_wb_i) begin
            if (!ctrl_op_lsu_load_i || lsu_valid_i) begin
              rf_wb_d  = ctrl_rf_wb_i & (|ctrl_rfd_adr_i);
              rfd_d    = ctrl_rfd_adr_i;
              result_d = ctrl_op_lsu_load_i
                       ? align(lsu_dat_i, ctrl_lsu_length_i,
                               ctrl_lsu_zext_i, ctrl_lsu_adr_i)
                       : ctrl_alu_result_i;
            end else begin
              ld_rf_wb_d = ctrl_rf_wb_i;
              ld_rfd_d   = ctrl_rfd_adr_i;
              ld_len_d   = ctrl_lsu_length_i;
              ld_zext_d  = ctrl_lsu_zext_i;
              ld_adr_d   = ctrl_lsu_adr_i;
              state_d    = WAIT_LOAD;
            end
          end
        end
        default: begin
          if (lsu_valid_i) begin
            rf_wb_d  = ld_rf_wb_q & (|ld_rfd_q);
            rfd_d    = ld_rfd_q;
            result_d = align(lsu_dat_i, ld_len_q, ld_zext_q, ld_adr_q);
            state_d  = IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rf_wb_q    <= 1'b0;
      rfd_q      <= '0;
      result_q   <= '0;
      ld_rf_wb_q <= 1'b0;
      ld_rfd_q   <= '0;
      ld_len_q   <= 2'b00;
      ld_zext_q  <= 1'b0;
      ld_adr_q   <= 2'b00;
    end else begin
      state_q    <= state_d;
      rf_wb_q    <= rf_wb_d;
      rfd_q      <= rfd_d;
      result_q   <= result_d;
      ld_rf_wb_q <= ld_rf_wb_d;
      ld_rfd_q   <= ld_rfd_d;
      ld_len_q   <= ld_len_d;
      ld_zext_q  <= ld_zext_d;
      ld_adr_q   <= ld_adr_d;
    end
  end

  assign wb_rf_wb_o   = rf_wb_q;
  assign wb_rfd_adr_o = rfd_q;
  assign result_o     = result_q;
  assign wb_stall_o   = (state_q == WAIT_LOAD);

endmodule

// File: tb/tb_mor1kx_wb_stage_cappuccino.sv
// Directed bench for the writeback stage: cycle-by-cycle vector table
// plus a reset-during-load sequence.
module tb_mor1kx_wb_stage_cappuccino;

  logic        clk = 1'b0;
  logic        rst;
  logic        padv, flush, rf_wb, load, zext, valid;
  logic [4:0]  rfd;
  logic [31:0] alu, dat;
  logic [1:0]  len, adr;
  logic        wb_o, stall_o;
  logic [4:0]  rfd_o;
  logic [31:0] res_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mor1kx_wb_stage_cappuccino dut (
    .clk(clk), .rst(rst),
    .padv_wb_i(padv), .pipeline_flush_i(flush),
    .ctrl_rf_wb_i(rf_wb), .ctrl_rfd_adr_i(rfd),
    .ctrl_alu_result_i(alu), .ctrl_op_lsu_load_i(load),
    .ctrl_lsu_length_i(len), .ctrl_lsu_zext_i(zext),
    .ctrl_lsu_adr_i(adr), .lsu_dat_i(dat), .lsu_valid_i(valid),
    .wb_rf_wb_o(wb_o), .wb_rfd_adr_o(rfd_o),
    .result_o(res_o), .wb_stall_o(stall_o)
  );

  typedef struct {
    logic        padv, flush, rf_wb;
    logic [4:0]  rfd;
    logic [31:0] alu;
    logic        load;
    logic [1:0]  len;
    logic        zext;
    logic [1:0]  adr;
    logic [31:0] dat;
    logic        valid;
    logic        e_wb;
    logic [4:0]  e_rfd;
    logic [31:0] e_res;
    logic        e_stall;
  } vec_t;

  localparam int NV = 19;
  vec_t v [NV];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_wb,
                         input logic [4:0] e_rfd,
                         input logic [31:0] e_res, input logic e_st);
    chk({tag, ".wb"}, {31'd0, wb_o}, {31'd0, e_wb});
    chk({tag, ".rfd"}, {27'd0, rfd_o}, {27'd0, e_rfd});
    chk({tag, ".res"}, res_o, e_res);
    chk({tag, ".stall"}, {31'd0, stall_o}, {31'd0, e_st});
  endtask

  task automatic idle_in;
    padv = 0; flush = 0; rf_wb = 0; rfd = 0; alu = 0; load = 0;
    len = 0; zext = 0; adr = 0; dat = 0; valid = 0;
  endtask

  task automatic apply(input vec_t x);
    padv = x.padv; flush = x.flush; rf_wb = x.rf_wb; rfd = x.rfd;
    alu = x.alu; load = x.load; len = x.len; zext = x.zext;
    adr = x.adr; dat = x.dat; valid = x.valid;
  endtask

  initial begin
    // padv flush rfwb rfd alu load len zext adr dat valid | wb rfd res stall
    v[0]  = '{1,0,1,3,32'h12345678,0,0,0,0,0,0,
              1,3,32'h12345678,0};
    v[1]  = '{0,0,0,0,0,0,0,0,0,0,0, 0,3,32'h12345678,0};
    v[2]  = '{1,0,1,7,0,1,2'b00,0,1,32'h0080FF00,1,
              1,7,32'hFFFFFF80,0};
    v[3]  = '{0,0,0,0,0,0,0,0,0,0,0, 0,7,32'hFFFFFF80,0};
    v[4]  = '{1,0,1,9,0,1,2'b01,1,2,0,0, 0,7,32'hFFFFFF80,1};
    v[5]  = '{1,0,1,4,32'h55555555,0,0,0,0,0,0,
              0,7,32'hFFFFFF80,1};
    v[6]  = '{0,0,0,0,0,0,0,0,0,0,0, 0,7,32'hFFFFFF80,1};
    v[7]  = '{0,0,0,0,0,0,2'b00,0,0,32'h1234FF00,1,
              1,9,32'h0000FF00,0};
    v[8]  = '{1,0,1,0,32'hCAFEBABE,0,0,0,0,0,0,
              0,0,32'hCAFEBABE,0};
    v[9]  = '{0,0,1,8,0,1,0,0,0,32'h11111111,1,
              0,0,32'hCAFEBABE,0};
    v[10] = '{1,0,1,5,0,1,2'b10,0,0,0,0, 0,0,32'hCAFEBABE,1};
    v[11] = '{0,1,0,0,0,0,0,0,0,32'hDEADBEEF,1,
              0,0,32'hCAFEBABE,0};
    v[12] = '{0,0,0,0,0,0,0,0,0,32'hDEADBEEF,1,
              0,0,32'hCAFEBABE,0};
    v[13] = '{1,1,1,6,32'h0BADF00D,0,0,0,0,0,0,
              0,0,32'hCAFEBABE,0};
    v[14] = '{1,0,1,31,0,1,2'b00,1,3,32'hAABBCCF0,1,
              1,31,32'h000000F0,0};
    v[15] = '{1,0,1,2,0,1,2'b00,0,0,32'h7F000000,1,
              1,2,32'h0000007F,0};
    v[16] = '{1,0,1,2,0,1,2'b01,0,0,32'h80010000,1,
              1,2,32'hFFFF8001,0};
    v[17] = '{1,0,0,4,0,1,2'b10,0,0,32'hDEADBEEF,1,
              0,4,32'hDEADBEEF,0};
    v[18] = '{1,0,1,6,0,1,2'b00,0,2,32'h00009C00,1,
              1,6,32'hFFFFFF9C,0};

    idle_in();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0);
    rst = 0;

    for (int i = 0; i < NV; i++) begin
      apply(v[i]);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), v[i].e_wb, v[i].e_rfd,
              v[i].e_res, v[i].e_stall);
    end

    // Reset while a load is outstanding abandons it.
    idle_in();
    padv = 1; rf_wb = 1; rfd = 12; load = 1; len = 2'b10;
    @(posedge clk);
    #1;
    chk_all("rstw.wait", 0, 6, 32'hFFFFFF9C, 1);
    idle_in();
    rst = 1; valid = 1; dat = 32'h87654321;
    @(posedge clk);
    #1;
    chk_all("rstw.rst", 0, 0, 0, 0);
    rst = 0;
    @(posedge clk);
    #1;
    chk_all("rstw.after", 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
